// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: stall bus type, Stop/NoStop levels and
// the two stall encodings driven onto the bus by hazard_ctrl.
package hazard_ctrl_pkg;

    // Stall bus bit order: 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB, 5=WB.
    localparam int STALL_BUS_W = 6;

    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam stall_bus_t STALL_NONE = '0;

    // Load-use: hold PC and IF/ID, and ID/EX takes a bubble.
    localparam stall_bus_t STALL_LU = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};

    // Mult/div: freeze everything up to and including EX/MEM.
    localparam stall_bus_t STALL_EX = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};

endpackage

// File: rtl/hazard_ctrl_md_watchdog.sv
// Hang watchdog for the mult/div unit: counts MD_BUSY cycles without a result
// and flags a timeout on the cycle the count reaches TIMEOUT-1.
module md_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic md_ready,
    output logic fire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign fire = busy && !md_ready && (cnt == CW'(TIMEOUT - 1));

    // Count waiting cycles; clear whenever the controller is not waiting or leaves MD_BUSY.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (rst) begin
            cnt <= '0;
        end else if (!busy || md_ready || fire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use detection, mult/div hold with a
// start/ready handshake, stall-cycle counter and mult/div hang watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int STALL_W    = 6,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_load,
    input  logic               ex_rf_we,
    input  logic [4:0]         ex_rf_waddr,
    input  logic               id_rs_re,
    input  logic               id_rt_re,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               md_req,
    input  logic               md_ready,
    output logic               md_start,
    output logic [STALL_W-1:0] stall,
    output logic               md_err,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    stall_bus_t stall_c;
    logic       lu_hz;
    logic       md_busy;
    logic       wd_fire;

    // ID reads the register a load in EX is about to produce; r0 never hazards.
    assign lu_hz = ex_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                   ((id_rs_re && (id_rs == ex_rf_waddr)) ||
                    (id_rt_re && (id_rt == ex_rf_waddr)));

    assign md_busy = (state == MD_BUSY);

    md_watchdog #(
        .TIMEOUT (MD_TIMEOUT)
    ) u_md_watchdog (
        .clk      (clk),
        .rst      (rst),
        .busy     (md_busy),
        .md_ready (md_ready),
        .fire     (wd_fire)
    );

    // Next state, stall bus and start pulse; outputs are idle while in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        stall_c   = STALL_NONE;
        md_start  = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (md_req) begin
                        stall_c   = STALL_EX;
                        md_start  = 1'b1;
                        state_nxt = MD_BUSY;
                    end else if (lu_hz) begin
                        stall_c = STALL_LU;
                    end
                end
                MD_BUSY: begin
                    if (md_ready || wd_fire) begin
                        state_nxt = RUN;
                    end else begin
                        stall_c = STALL_EX;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign stall = STALL_W'(stall_c);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky watchdog error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_err <= 1'b0;
        end else if (wd_fire) begin
            md_err <= 1'b1;
        end
    end

    // Saturating count of cycles with any stall bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((stall_c != STALL_NONE) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
